// File: rtl/logic_unit_pipe_if.sv
// Producer/consumer handshake bundle for logic_unit_pipe.
// ZERO/PARITY signals exist only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             zero;
  logic             parity;
`endif

  // Environment side: drives operands and consumer ready.
  modport master (
    output a, b, op, in_valid, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    input  zero, parity,
`endif
    input  in_ready, y, out_valid
  );

  // Block side.
  modport slave (
    input  a, b, op, in_valid, out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    output zero, parity,
`endif
    output in_ready, y, out_valid
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a 2-entry skid buffer on the result path.
// Optional per-result ZERO/PARITY flags enabled by LOGIC_UNIT_FLAGS_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  logic_unit_pipe_if.slave   bus
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int unsigned FLAG_W  = 2;
`else
  localparam int unsigned FLAG_W  = 0;
`endif
  localparam int unsigned ENTRY_W = WIDTH + FLAG_W;

  logic [WIDTH-1:0]   res_c;
  logic [ENTRY_W-1:0] entry_c;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               push_c;
  logic               pop_c;

  // Bitwise operation select
  always_comb begin
    res_c = '0;
    case (bus.op)
      3'd0: res_c = bus.a & bus.b;
      3'd1: res_c = bus.a | bus.b;
      3'd2: res_c = bus.a ^ bus.b;
      3'd3: res_c = ~(bus.a & bus.b);
      3'd4: res_c = ~(bus.a | bus.b);
      3'd5: res_c = ~(bus.a ^ bus.b);
      3'd6: res_c = ~bus.a;
      3'd7: res_c = bus.a;
      default: res_c = '0;
    endcase
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  assign entry_c = {^res_c, (res_c == '0), res_c};
`else
  assign entry_c = res_c;
`endif

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  // Buffer next state; head is cleared on drain so stale data never shows on y
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push_c) begin
          head_d  = entry_c;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_c && pop_c) begin
          head_d  = entry_c;
        end else if (push_c) begin
          tail_d  = entry_c;
          count_d = 2'd2;
        end else if (pop_c) begin
          head_d  = '0;
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop_c) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: begin
        head_d  = '0;
        count_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= (count_d != 2'd2);
      out_valid_q <= (count_d != 2'd0);
    end
  end

  assign bus.y         = head_q[WIDTH-1:0];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
`ifdef LOGIC_UNIT_FLAGS_EN
  assign bus.zero      = head_q[WIDTH];
  assign bus.parity    = head_q[WIDTH+1];
`endif

endmodule
